// File: rtl/dff_pipe_array.sv
// dff_pipe_array
// --------------
// Enable-gated delay line for a 2-D unpacked array of WIDTH-bit words.
// Each element [i][j] is its own PIPE_DEPTH-stage shift register. All
// elements share one clock, one enable and one reset. Side-band data
// therefore leaves the block PIPE_DEPTH enabled cycles after it entered,
// lined up with a datapath result of the same latency.
//
// Parameters
//   WIDTH         bits per element
//   ARRAY_SIZE1   outer array dimension
//   ARRAY_SIZE2   inner array dimension (1 for 1-D users)
//   PIPE_DEPTH    register stages, 0..64. With 0 the block is a wire.
//   RETIME_STATUS 0: stage registers are pinned. 1: synthesis may retime them.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low clear of every stage
//   en     when high, all stages advance together on the clock edge
//   in     [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
//   out    [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
module dff_pipe_array #(
  parameter int WIDTH         = 1,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
  output logic [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);

  // A zero-depth line has no registers, so the control inputs are left
  // unused on purpose.
  if (PIPE_DEPTH == 0) begin : g_no_regs
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
  end

  for (genvar gi = 0; gi < ARRAY_SIZE1; gi++) begin : g_outer
    for (genvar gj = 0; gj < ARRAY_SIZE2; gj++) begin : g_inner

      if (PIPE_DEPTH == 0) begin : g_wire
        assign out[gi][gj] = in[gi][gj];

      end else if (RETIME_STATUS != 0) begin : g_retime
        // The two branches differ only in the synthesis attribute on the
        // stage storage. The shift behaviour is identical.
        (* retiming_forward = 1, retiming_backward = 1 *)
        logic [WIDTH-1:0] stage [0:PIPE_DEPTH-1];

        // All stages move together, or none move. Reset wipes in-flight data.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            stage <= '{default: '0};
          end else if (en) begin
            stage[0] <= in[gi][gj];
            for (int k = 1; k < PIPE_DEPTH; k++) begin
              stage[k] <= stage[k-1];
            end
          end
        end

        assign out[gi][gj] = stage[PIPE_DEPTH-1];

      end else begin : g_fixed
        (* retiming_forward = 0, retiming_backward = 0 *)
        logic [WIDTH-1:0] stage [0:PIPE_DEPTH-1];

        // Same shift register as above, with retiming disabled.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            stage <= '{default: '0};
          end else if (en) begin
            stage[0] <= in[gi][gj];
            for (int k = 1; k < PIPE_DEPTH; k++) begin
              stage[k] <= stage[k-1];
            end
          end
        end

        assign out[gi][gj] = stage[PIPE_DEPTH-1];
      end

    end
  end

endmodule

// File: tb/tb_dff_pipe_array.sv
// tb_dff_pipe_array
// -----------------
// Drives four instances of dff_pipe_array:
//   dut3   24-bit, 3x3, depth 3, retiming allowed
//   dut2   24-bit, 3x3, depth 2, fed the same stream as dut3
//   dut0   24-bit, 3x3, depth 0
//   dutf    1-bit, 4x1, depth 3, valid-flag style
// The reference model is a history queue holding the array value accepted
// at each enabled edge. A depth-D line must show the entry D accepts back.
// Reset empties the history and refills it with zeros.
module tb_dff_pipe_array;

  logic        clk;
  logic        reset;
  logic        en;
  logic [23:0] in_a  [2:0][2:0];
  logic [23:0] out3  [2:0][2:0];
  logic [23:0] out2  [2:0][2:0];
  logic [23:0] out0  [2:0][2:0];
  logic [0:0]  in_f  [3:0][0:0];
  logic [0:0]  out_f [3:0][0:0];

  int n_checks;
  int n_fail;

  logic [215:0] hist_a [$];
  logic [3:0]   hist_f [$];

  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3),
                   .PIPE_DEPTH(3), .RETIME_STATUS(1)) dut3 (
    .clk(clk), .reset(reset), .en(en), .in(in_a), .out(out3));

  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3),
                   .PIPE_DEPTH(2), .RETIME_STATUS(0)) dut2 (
    .clk(clk), .reset(reset), .en(en), .in(in_a), .out(out2));

  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3),
                   .PIPE_DEPTH(0), .RETIME_STATUS(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .in(in_a), .out(out0));

  dff_pipe_array #(.WIDTH(1), .ARRAY_SIZE1(4), .ARRAY_SIZE2(1),
                   .PIPE_DEPTH(3), .RETIME_STATUS(0)) dutf (
    .clk(clk), .reset(reset), .en(en), .in(in_f), .out(out_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [215:0] pack_a(input logic [23:0] a [2:0][2:0]);
    logic [215:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[(i*3+j)*24 +: 24] = a[i][j];
    return r;
  endfunction

  function automatic logic [3:0] pack_f(input logic [0:0] a [3:0][0:0]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = a[i][0];
    return r;
  endfunction

  function automatic logic [215:0] rand_a();
    logic [215:0] r;
    for (int k = 0; k < 9; k++) r[k*24 +: 24] = 24'($urandom);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [215:0] observed,
                             input logic [215:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    hist_a.delete();
    hist_f.delete();
    repeat (3) begin
      hist_a.push_back('0);
      hist_f.push_back('0);
    end
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, "_d3"}, pack_a(out3), hist_a[hist_a.size()-3]);
    checkOutput({tag, "_d2"}, pack_a(out2), hist_a[hist_a.size()-2]);
    checkOutput({tag, "_d0"}, pack_a(out0), pack_a(in_a));
    checkOutput({tag, "_flag"}, {212'b0, pack_f(out_f)},
                {212'b0, hist_f[hist_f.size()-3]});
  endtask

  task automatic applyStimulus(input logic en_v, input logic [215:0] a_v,
                               input logic [3:0] f_v);
    en = en_v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        in_a[i][j] = a_v[(i*3+j)*24 +: 24];
    for (int i = 0; i < 4; i++) in_f[i][0] = f_v[i];
  endtask

  // One clock cycle. Inputs are already stable. The model records what an
  // enabled edge accepts, and outputs are checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset === 1'b1 && en === 1'b1) begin
      hist_a.push_back(pack_a(in_a));
      hist_f.push_back(pack_f(in_f));
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Pulse reset between edges. The outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 reset = 1'b1;
  endtask

  logic [215:0] v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    applyStimulus(1'b0, '0, 4'b0);

    #1 reset = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Latency: element [0][0] carries 1,2,3,4 and the rest stay zero.
    for (int s = 1; s <= 4; s++) begin
      applyStimulus(1'b1, 216'(s), 4'b0);
      tick("latency");
    end
    applyStimulus(1'b1, '0, 4'b0);
    repeat (3) tick("latency_drain");

    // Stall: load A then B, then hold en low while the input wanders.
    applyStimulus(1'b1, rand_a(), 4'b0);
    tick("load_a");
    applyStimulus(1'b1, rand_a(), 4'b0);
    tick("load_b");
    repeat (3) begin
      applyStimulus(1'b0, rand_a(), 4'($urandom));
      tick("stall");
    end
    applyStimulus(1'b1, rand_a(), 4'b0);
    tick("resume");

    // Mid-stream reset with every stage full of 0xABCDEF.
    applyStimulus(1'b1, {9{24'hABCDEF}}, 4'hF);
    repeat (3) tick("fill");
    reset_pulse("mid_reset");
    applyStimulus(1'b1, {9{24'h123456}}, 4'h5);
    repeat (4) tick("after_reset");

    // Depth 0: change the input with no clock edge and check the output.
    #1 v = rand_a();
    applyStimulus(1'b1, v, 4'b0);
    #1 checkOutput("d0_comb", pack_a(out0), v);

    // Depth skew: one step change, then a constant input.
    applyStimulus(1'b1, rand_a(), 4'b0);
    repeat (4) tick("skew");

    // Valid flags: lane patterns 1010 then 0101, then idle.
    applyStimulus(1'b1, '0, 4'b1010);
    tick("flag_a");
    applyStimulus(1'b1, '0, 4'b0101);
    tick("flag_b");
    applyStimulus(1'b1, '0, 4'b0000);
    repeat (4) tick("flag_drain");

    // Random traffic: mostly enabled, with an occasional reset pulse.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(($urandom_range(0, 9) < 7), rand_a(), 4'($urandom));
      tick("random");
      if ($urandom_range(0, 29) == 0) reset_pulse("random_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
